// File: rtl/apb_sin_pkg.sv
// Shared types and default register map for the APB sin sweep master.
package apb_sin_pkg;

  typedef enum logic [2:0] {
    IDLE, SETUP_W, ACCESS_W, SETUP_R, ACCESS_R, WAIT_SPACE, DONE
  } state_t;

  localparam logic [31:0] DEF_CTRL_ADDR = 32'h0;
  localparam logic [31:0] DEF_OUT_ADDR  = 32'h4;

endpackage

// File: rtl/apb_sin_fifo.sv
// First-word-fall-through result FIFO; push is ignored when full, pop when empty.
module apb_sin_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is masked while empty so stale storage never leaks out after reset.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/apb_sin_sweep.sv
// APB master that sweeps x over count samples of the sin slave and queues
// every result word in a FIFO for the consumer.
module apb_sin_sweep
  import apb_sin_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR  = DEF_CTRL_ADDR,
  parameter logic [31:0] OUT_ADDR   = DEF_OUT_ADDR,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [31:0] start_x,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [31:0]   x, hold;
  logic [15:0]   rem;
  logic [TW-1:0] tcnt;
  logic          push, full, empty, tmo, tmo_hit, last;

  assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));
  assign last    = (rem == 16'd1);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    tmo      = 1'b0;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    case (state)
      IDLE: if (start) state_nx = (count == '0) ? DONE : SETUP_W;
      SETUP_W: begin
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = CTRL_ADDR; PWDATA = x;
        state_nx = ACCESS_W;
      end
      ACCESS_W: begin
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = CTRL_ADDR; PWDATA = x;
        if (PREADY)       state_nx = SETUP_R;
        else if (tmo_hit) begin tmo = 1'b1; state_nx = DONE; end
      end
      SETUP_R: begin
        PSEL = 1'b1; PADDR = OUT_ADDR;
        state_nx = ACCESS_R;
      end
      ACCESS_R: begin
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = OUT_ADDR;
        if (PREADY) begin
          // A full FIFO parks the word in hold and leaves the bus idle.
          if (!full) begin push = 1'b1; state_nx = last ? DONE : SETUP_W; end
          else state_nx = WAIT_SPACE;
        end else if (tmo_hit) begin
          tmo = 1'b1; state_nx = DONE;
        end
      end
      WAIT_SPACE: if (!full) begin push = 1'b1; state_nx = last ? DONE : SETUP_W; end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      x     <= '0;
      rem   <= '0;
      hold  <= '0;
      tcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        x   <= start_x;
        rem <= count;
        err <= 1'b0;
      end
      if (push) begin
        x   <= x + 32'd1;
        rem <= rem - 16'd1;
      end
      if (state == ACCESS_R && PREADY && full) hold <= PRDATA;
      if (tmo) err <= 1'b1;
      if (state_nx != state) tcnt <= '0;
      else if (state == ACCESS_W || state == ACCESS_R) tcnt <= tcnt + TW'(1);
    end
  end

  apb_sin_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (push),
    .wdata ((state == WAIT_SPACE) ? hold : PRDATA),
    .full  (full),
    .pop   (res_ready),
    .empty (empty),
    .rdata (res_data)
  );

  assign res_valid = !empty;

endmodule

// File: tb/tb_apb_sin_sweep.sv
// Bench: sin slave model, result/write scoreboards and directed plus random sweeps.
module tb_apb_sin_sweep;
  import apb_sin_pkg::*;

  localparam logic [31:0] TBL [8] = '{32'h0, 32'h3F3504F3, 32'h1, 32'h3F3504F3,
                                      32'h0, 32'hC0CAFB0C, 32'hFFFFFFFE, 32'hC0CAFB0C};

  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic start = 1'b0, res_ready = 1'b0;
  logic [31:0] start_x = '0;
  logic [15:0] count = '0;
  logic busy, done, err, res_valid, PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] res_data, PADDR, PWDATA, PRDATA;

  logic start2 = 1'b0;
  logic busy2, done2, err2, res_valid2, PSEL2, PENABLE2, PWRITE2, PREADY2;
  logic [31:0] res_data2, PADDR2, PWDATA2, PRDATA2;

  always #5 PCLK = ~PCLK;

  apb_sin_sweep dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .start_x(start_x), .count(count),
    .busy(busy), .done(done), .err(err), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA));

  apb_sin_sweep #(.CTRL_ADDR(32'h8)) dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start2), .start_x(32'h0), .count(16'd3),
    .busy(busy2), .done(done2), .err(err2), .res_valid(res_valid2), .res_data(res_data2),
    .res_ready(1'b1), .PSEL(PSEL2), .PENABLE(PENABLE2), .PWRITE(PWRITE2),
    .PADDR(PADDR2), .PWDATA(PWDATA2), .PREADY(PREADY2), .PRDATA(PRDATA2));

  // Sin slave: control at 0, result at 4, PREADY one cycle after PENABLE.
  function automatic logic acks(input logic w, input logic [31:0] a);
    return w ? (a == 32'h0) : (a == 32'h4);
  endfunction

  logic [31:0] sx, sx2;
  logic srdy, srdy2;
  always @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      srdy <= 1'b0; sx <= '0; srdy2 <= 1'b0; sx2 <= '0;
    end else begin
      srdy  <= PSEL && PENABLE && !srdy && acks(PWRITE, PADDR);
      if (PSEL && PENABLE && srdy && PWRITE) sx <= PWDATA;
      srdy2 <= PSEL2 && PENABLE2 && !srdy2 && acks(PWRITE2, PADDR2);
      if (PSEL2 && PENABLE2 && srdy2 && PWRITE2) sx2 <= PWDATA2;
    end
  assign PREADY  = srdy;
  assign PRDATA  = TBL[sx[2:0]];
  assign PREADY2 = srdy2;
  assign PRDATA2 = TBL[sx2[2:0]];

  int checks = 0, errors = 0;
  int cyc = 0, rd_cnt = 0, last_rd = -1, zero_at = -1, psel_cnt = 0;
  int acc2 = 0, last_acc2 = 0, done2_cyc = 0;
  bit timing = 0, done_hit = 0, done2_hit = 0, prev_done = 0;
  logic [31:0] exp_x[$], exp_res[$], wr_log[$], got_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference model: an accepted start (DUT idle) queues count writes of x, x+1, ...
  // and the matching sin results; everything observed must come out in that order.
  task automatic monitor();
    logic [31:0] xv;
    if (!PRESETn) begin
      exp_x.delete(); exp_res.delete(); prev_done = 0; zero_at = -1;
      return;
    end
    cyc++;
    if (start && !busy) begin
      if (count == 16'd0) zero_at = cyc;
      for (int i = 0; i < int'(count); i++) begin
        xv = start_x + 32'(i);
        exp_x.push_back(xv);
        exp_res.push_back(TBL[xv[2:0]]);
      end
      last_rd = -1;
    end
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        wr_log.push_back(PWDATA);
        if (exp_x.size() == 0) begin
          checks++; errors++;
          $display("FAIL pwdata_extra: got %h expected no write", PWDATA);
        end else chk("pwdata", PWDATA, exp_x.pop_front());
      end else begin
        rd_cnt++;
        if (timing && last_rd >= 0) chki("sample_period", cyc - last_rd, 6);
        last_rd = cyc;
      end
    end
    if (res_valid && res_ready) begin
      got_log.push_back(res_data);
      if (exp_res.size() == 0) begin
        checks++; errors++;
        $display("FAIL res_extra: got %h expected no result", res_data);
      end else chk("res_data", res_data, exp_res.pop_front());
    end
    if (done) begin
      done_hit = 1;
      chkb("done_pulse", prev_done, 1'b0);
      if (timing) chki("done_after_push", cyc - last_rd, 1);
      if (zero_at >= 0) begin chki("done_after_start_cnt0", cyc - zero_at, 1); zero_at = -1; end
    end
    if (PENABLE) chkb("penable_needs_psel", PSEL, 1'b1);
    if (PSEL) psel_cnt++;
    prev_done = done;
    if (PSEL2 && PENABLE2) begin acc2++; last_acc2 = cyc; end
    if (done2) begin
      done2_hit = 1; done2_cyc = cyc;
      chkb("tmo_psel_at_done", PSEL2, 1'b0);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
    monitor();
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] sx_i, input logic [15:0] cnt_i);
    start_x = sx_i; count = cnt_i; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string nm);
    int n;
    n = 0;
    while (!done_hit && n < lim) begin tick(); n++; end
    if (!done_hit) begin
      checks++; errors++;
      $display("FAIL %s: got timeout after %0d cycles expected done", nm, lim);
    end
    done_hit = 0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int i = 0; i < 20 && res_valid; i++) tick();
  endtask

  initial begin
    int rd_base, psel_base, n;
    bit found;
    tick(); tick();
    chki("rst_ctrl_bits", int'({PSEL, PENABLE, PWRITE, busy, done, err, res_valid}), 0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    PRESETn = 1'b1;
    tick();

    // Eight samples from x=0, consumer always ready.
    timing = 1; res_ready = 1'b1; got_log.delete(); done_hit = 0;
    pulse_start(32'h0, 16'd8);
    chkb("busy_after_start", busy, 1'b1);
    wait_done(200, "t1_done");
    timing = 0;
    chki("t1_count", got_log.size(), 8);
    for (int i = 0; i < 8 && i < got_log.size(); i++) chk("t1_literal", got_log[i], TBL[i]);
    chk("t1_lit_1", (got_log.size() > 1) ? got_log[1] : 32'hX, 32'h3F3504F3);
    chk("t1_lit_6", (got_log.size() > 6) ? got_log[6] : 32'hX, 32'hFFFFFFFE);
    chkb("t1_err", err, 1'b0);
    chkb("t1_idle", busy, 1'b0);

    // count=0: straight to done, no bus traffic.
    psel_base = psel_cnt;
    pulse_start(32'h1234, 16'd0);
    wait_done(10, "t2_done");
    chki("t2_no_apb", psel_cnt - psel_base, 0);

    // count=12 with consumer stalled: FIFO fills, ninth word parks.
    res_ready = 1'b0; got_log.delete(); rd_base = rd_cnt;
    pulse_start(32'h5, 16'd12);
    for (int i = 0; i < 100; i++) tick();
    chki("t3_state", int'(dut.state), int'(WAIT_SPACE));
    chkb("t3_psel", PSEL, 1'b0);
    chkb("t3_busy", busy, 1'b1);
    chkb("t3_valid", res_valid, 1'b1);
    chki("t3_reads", rd_cnt - rd_base, 9);
    res_ready = 1'b1;
    wait_done(200, "t3_done");
    drain();
    chki("t3_all_out", got_log.size(), 12);
    chki("t3_sb_empty", exp_res.size(), 0);

    // Timeout: slave never acks a write to 8.
    start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (!done2_hit && n < 60) begin tick(); n++; end
    chkb("tmo_done_seen", done2_hit, 1'b1);
    chki("tmo_access_cycles", acc2, 16);
    chki("tmo_done_latency", done2_cyc - last_acc2, 1);
    chkb("tmo_err", err2, 1'b1);
    chkb("tmo_fifo_empty", res_valid2, 1'b0);
    tick();
    chkb("tmo_err_sticky", err2, 1'b1);
    chkb("tmo_idle", busy2, 1'b0);

    // x wraps through 32'hFFFFFFFF.
    wr_log.delete();
    pulse_start(32'hFFFFFFFE, 16'd3);
    wait_done(100, "t5_done");
    chki("t5_writes", wr_log.size(), 3);
    chk("t5_w0", (wr_log.size() > 0) ? wr_log[0] : 32'hX, 32'hFFFFFFFE);
    chk("t5_w1", (wr_log.size() > 1) ? wr_log[1] : 32'hX, 32'hFFFFFFFF);
    chk("t5_w2", (wr_log.size() > 2) ? wr_log[2] : 32'hX, 32'h0);
    drain();

    // Reset in the middle of a read access.
    res_ready = 1'b0; rd_base = rd_cnt; found = 0;
    pulse_start(32'h9, 16'd4);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = (rd_cnt - rd_base >= 1) && PSEL && PENABLE && !PWRITE;
    end
    chkb("t6_in_access_r", found, 1'b1);
    chkb("t6_fifo_had_data", res_valid, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chki("t6_ctrl_bits", int'({PSEL, PENABLE, PWRITE, busy, done, err, res_valid}), 0);
    chk("t6_paddr", PADDR, 32'h0);
    chk("t6_pwdata", PWDATA, 32'h0);
    chk("t6_res_data", res_data, 32'h0);
    tick(); tick();
    PRESETn = 1'b1;
    tick();
    res_ready = 1'b1; got_log.delete(); done_hit = 0;
    pulse_start(32'h3, 16'd2);
    wait_done(100, "t6_restart_done");
    drain();
    chki("t6_restart_count", got_log.size(), 2);

    // Random sweeps, random consumer, a start ignored mid-sweep.
    for (int r = 0; r < 6; r++) begin
      pulse_start($urandom, 16'($urandom_range(1, 9)));
      n = 0;
      while (!done_hit && n < 400) begin
        res_ready = 1'($urandom_range(0, 1));
        start = (n == 4);
        if (n == 4) start_x = $urandom;
        tick();
        n++;
      end
      start = 1'b0;
      if (!done_hit) begin
        checks++; errors++;
        $display("FAIL rnd_done: got timeout expected done in run %0d", r);
      end
      done_hit = 0;
      drain();
      chki("rnd_res_empty", exp_res.size(), 0);
      chki("rnd_x_empty", exp_x.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
